// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default widths.
package seq_divider_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   p_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   p_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] diff;

  always_comb begin
    t    = {p_i[DIVISOR_W-1:0], bit_i};
    diff = t - {1'b0, divisor_i};
    // A set MSB of P means the true shifted value already exceeds any divisor.
    q_o  = p_i[DIVISOR_W] | (t >= {1'b0, divisor_i});
    p_o  = q_o ? diff : t;
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// fixed DIVIDEND_W+1 cycle latency from accepted start to done.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  div_zero_q, div_zero_d;

  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    p_q, p_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;

  logic [DIVISOR_W:0]    step_p;
  logic                  step_q;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .p_i       (p_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_o       (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    quo_d       = quo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
          state_d = RUN;
        end
      end

      RUN: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        p_d   = step_p;
        quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == '0) begin
          // Results land in the output registers on the same edge that enters FIN,
          // so they are already valid while done is high.
          state_d = FIN;
          done_d  = 1'b1;
          if (dvs_q == '0) begin
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
          end else begin
            quotient_d  = {quo_q[DIVIDEND_W-2:0], step_q};
            remainder_d = step_p[DIVISOR_W-1:0];
            div_zero_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
    p_q   <= p_d;
    quo_q <= quo_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule : seq_divider
